dcache_assoc: RTL and testbench
===============================

// Module: dcache_assoc
// PURPOSE
//  Parametrised N-way set-associative write-back/write-allocate data cache between core LSU and memory arbiter.
//  Adds over single-purpose 2-way cache: configurable ways/sets, byte-strobe stores, true-LRU, single-line flush and whole-cache flush.
//  Core side: enable/done pulse protocol; memory side: drequest/dreqack/ddone line protocol, unchanged so arbiter is reused.
// PARAMETERS
//  WAYS       4    associativity, power of two, 1..8
//  SET_BITS   6    log2(number of sets)
//  LINE_BYTES 64   line size in bytes (fixed 64; memory bus is 512 bits)
//  ADDR_W     64   address width; TAG_W = ADDR_W-6-SET_BITS
// PORTS
//  clk        in   1    clock; all state updates on posedge
//  reset_n    in   1    synchronous active-low reset
//  enable     in   1    request strobe, sampled only in IDLE
//  op         in   2    0=load 1=store 2=clflush(addr line) 3=flush_all
//  addr       in   64   byte address; must be 8-byte aligned (addr[2:0]==0)
//  wdata      in   64   store data
//  wstrb      in   8    store byte enables, bit i -> wdata[8i+:8]
//  rdata      out  64   load data, valid when done=1
//  done       out  1    one-cycle completion pulse
//  busy       out  1    1 whenever state != IDLE
//  drequest   out  1    memory request; held until dreqack
//  dreqack    in   1    arbiter accepted request
//  dwrenable  out  1    1=write line, 0=read line; valid with drequest
//  daddr      out  64   line address, [5:0]=0
//  dwdata     out  512  writeback line
//  drdata     in   512  fill line, valid when ddone
//  ddone      in   1    memory transaction complete (one pulse)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): all valid/dirty bits 0, LRU ages = way index, state IDLE; rdata=0 done=0 busy=0
//   drequest=0 dwrenable=0 daddr=0 dwdata=0. Reset mid-transaction abandons it; no done issued; memory ack/done ignored.
//  Storage: per set/way tag, V, D, 2..3-bit LRU age, 512-bit line; implemented as register arrays, read combinational.
//  States: IDLE, LOOKUP, WB, FILL, FLUSH_SCAN, FLUSH_WB.
//  IDLE: enable=1 latches op/addr/wdata/wstrb -> LOOKUP (or FLUSH_SCAN for op=3, scan index 0). enable ignored when busy.
//  LOOKUP hit load: rdata=line[addr[5:3]], done next cycle; total latency 2 cycles from enable.
//  LOOKUP hit store: merge bytes by wstrb, set D, done; same latency. wstrb=0 still counts as hit, D set.
//  Miss: victim = first invalid way (lowest index), else way with age WAYS-1. Victim V&D -> WB else FILL.
//  WB: drequest=1 dwrenable=1 daddr={victim tag,set,6'b0} dwdata=victim line; ddone -> FILL (victim V cleared).
//  FILL: drequest=1 dwrenable=0 daddr={addr[63:6],6'b0}; on ddone write line, V=1, D=(op==store), store merged
//   from drdata in same cycle; load returns drdata word; done pulse next cycle.
//  drequest deasserts cycle after dreqack; dwrenable falls with it. ddone before dreqack is accepted as both.
//  LRU: accessed way age->0; ways with age < old age increment; others unchanged. Applied on hit and fill.
//  clflush: hit&dirty -> FLUSH_WB then invalidate; hit clean -> invalidate; miss -> done. LRU untouched.
//  flush_all: FLUSH_SCAN walks set 0..2^SET_BITS-1, way 0..WAYS-1; each dirty line written via FLUSH_WB,
//   every line invalidated; done after last way of last set; one cycle per clean/invalid entry.
//  Unaligned addr (addr[2:0]!=0) on enable: $error in sim, request treated as aligned (low bits ignored).
// TESTING
//  1 Reset then load 0x1000 -> FILL read at daddr 0x1000, memory returns line with word1=0xAA; load 0x1008 -> rdata 0xAA, done 2 cycles, no drequest.
//  2 Store 0x1008 wdata 0x1122334455667788 wstrb 0x0F, then load -> rdata upper bytes old, lower = 0x55667788.
//  3 WAYS=4: fill 5 distinct tags in set 0, first dirty -> 5th miss writes back tag #1 (LRU) at its address, then fills.
//  4 clflush on dirty hit -> one write of line, then load same addr misses; clflush on miss -> done, no memory traffic.
//  5 Dirty lines in sets 0 and 63, flush_all -> exactly 2 writebacks in set order, done once, all later loads miss.
//  6 Assert reset_n=0 during WB before ddone -> outputs at reset values next cycle, subsequent ddone ignored, cache empty.

Source files
------------

// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative write-back / write-allocate data cache
// that sits between the core load/store unit and the memory arbiter.
//
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   enable, op, addr,      core request: op 0=load 1=store 2=clflush 3=flush_all,
//   wdata, wstrb           8-byte aligned address, store data and byte enables
//   rdata, done, busy      load data (valid with done), one-cycle completion
//                          pulse, busy while the controller is not idle
//   drequest, dreqack,     memory line request held until accepted, write/read
//   dwrenable, daddr,      select, line address, writeback line
//   dwdata
//   drdata, ddone          fill line and one-cycle completion from memory
module dcache_assoc #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SET_BITS   = 6,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned ADDR_W     = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [1:0]              op,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [63:0]             wdata,
    input  logic [7:0]              wstrb,
    output logic [63:0]             rdata,
    output logic                    done,
    output logic                    busy,
    output logic                    drequest,
    input  logic                    dreqack,
    output logic                    dwrenable,
    output logic [ADDR_W-1:0]       daddr,
    output logic [LINE_BYTES*8-1:0] dwdata,
    input  logic [LINE_BYTES*8-1:0] drdata,
    input  logic                    ddone
);

    localparam int unsigned LINE_W   = LINE_BYTES * 8;
    localparam int unsigned TAG_W    = ADDR_W - 6 - SET_BITS;
    localparam int unsigned NUM_SETS = 1 << SET_BITS;
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOOKUP     = 3'd1;
    localparam logic [2:0] S_WB         = 3'd2;
    localparam logic [2:0] S_FILL       = 3'd3;
    localparam logic [2:0] S_FLUSH_SCAN = 3'd4;
    localparam logic [2:0] S_FLUSH_WB   = 3'd5;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_STORE   = 2'd1;
    localparam logic [1:0] OP_CLFLUSH = 2'd2;
    localparam logic [1:0] OP_FLUSH   = 2'd3;

    // Line storage: register arrays with combinational read.
    logic [TAG_W-1:0]  tag_q   [NUM_SETS][WAYS];
    logic [LINE_W-1:0] data_q  [NUM_SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [NUM_SETS][WAYS];
    logic [WAYS-1:0]   valid_q [NUM_SETS];
    logic [WAYS-1:0]   dirty_q [NUM_SETS];

    logic [2:0]          state;
    logic [1:0]          r_op;
    logic [ADDR_W-1:3]   r_addr;
    logic [63:0]         r_wdata;
    logic [7:0]          r_wstrb;
    logic [WAY_W-1:0]    r_way;
    logic [SET_BITS-1:0] scan_set;
    logic [WAY_W-1:0]    scan_way;

    logic [SET_BITS-1:0] lk_set;
    logic [TAG_W-1:0]    lk_tag;
    logic [2:0]          lk_word;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                vic_found;
    logic [WAY_W-1:0]    victim_way;
    logic [WAY_W-1:0]    acc_way;
    logic [WAY_W-1:0]    old_age;
    logic [WAY_W-1:0]    lru_next [WAYS];
    logic [LINE_W-1:0]   hit_line;
    logic [LINE_W-1:0]   hit_merged;
    logic [LINE_W-1:0]   fill_line;
    logic                scan_last;
    logic [SET_BITS-1:0] fl_set;
    logic [WAY_W-1:0]    fl_way;

    function automatic logic [LINE_W-1:0] merge_store(
        input logic [LINE_W-1:0] line,
        input logic [2:0]        word,
        input logic [63:0]       wd,
        input logic [7:0]        ws
    );
        logic [LINE_W-1:0] r;
        logic [8:0]        base;
        r = line;
        for (int unsigned b = 0; b < 8; b++) begin
            base = {word, 3'(b), 3'b000};
            if (ws[b]) r[base +: 8] = wd[{3'(b), 3'b000} +: 8];
        end
        return r;
    endfunction

    assign busy    = (state != S_IDLE);
    assign lk_set  = r_addr[6 +: SET_BITS];
    assign lk_tag  = r_addr[ADDR_W-1 -: TAG_W];
    assign lk_word = r_addr[5:3];

    assign scan_last = (scan_set == '1) && (scan_way == WAY_W'(WAYS - 1));
    // Single-line flush reuses FLUSH_WB; the entry comes from the lookup
    // for clflush and from the scan pointer for flush_all.
    assign fl_set = (r_op == OP_FLUSH) ? scan_set : lk_set;
    assign fl_way = (r_op == OP_FLUSH) ? scan_way : r_way;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        vic_found  = 1'b0;
        victim_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[lk_set][WAY_W'(w)] && tag_q[lk_set][WAY_W'(w)] == lk_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[lk_set][WAY_W'(w)]) begin
                vic_found  = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!vic_found && age_q[lk_set][WAY_W'(w)] == WAY_W'(WAYS - 1)) begin
                vic_found  = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
    end

    // True LRU: accessed way becomes youngest, ways younger than it age by one.
    always_comb begin
        acc_way = (state == S_FILL) ? r_way : hit_way;
        old_age = age_q[lk_set][acc_way];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == acc_way)
                lru_next[w] = '0;
            else if (age_q[lk_set][WAY_W'(w)] < old_age)
                lru_next[w] = age_q[lk_set][WAY_W'(w)] + 1'b1;
            else
                lru_next[w] = age_q[lk_set][WAY_W'(w)];
        end
    end

    always_comb begin
        hit_line   = data_q[lk_set][hit_way];
        hit_merged = merge_store(hit_line, lk_word, r_wdata, r_wstrb);
        fill_line  = (r_op == OP_STORE) ? merge_store(drdata, lk_word, r_wdata, r_wstrb) : drdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            rdata     <= '0;
            drequest  <= 1'b0;
            dwrenable <= 1'b0;
            daddr     <= '0;
            dwdata    <= '0;
            r_op      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_way     <= '0;
            scan_set  <= '0;
            scan_way  <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[SET_BITS'(s)] <= '0;
                dirty_q[SET_BITS'(s)] <= '0;
                for (int unsigned w = 0; w < WAYS; w++)
                    age_q[SET_BITS'(s)][WAY_W'(w)] <= WAY_W'(w);
            end
        end else begin
            done <= 1'b0;
            // ddone arriving without a separate ack also retires the request.
            if (drequest && (dreqack || ddone)) begin
                drequest  <= 1'b0;
                dwrenable <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        r_op    <= op;
                        r_addr  <= addr[ADDR_W-1:3];
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                        if (op == OP_FLUSH) begin
                            scan_set <= '0;
                            scan_way <= '0;
                            state    <= S_FLUSH_SCAN;
                        end else begin
                            state <= S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (r_op == OP_CLFLUSH) begin
                        if (hit && dirty_q[lk_set][hit_way]) begin
                            r_way     <= hit_way;
                            drequest  <= 1'b1;
                            dwrenable <= 1'b1;
                            daddr     <= {tag_q[lk_set][hit_way], lk_set, 6'b0};
                            dwdata    <= hit_line;
                            state     <= S_FLUSH_WB;
                        end else begin
                            if (hit) valid_q[lk_set][hit_way] <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else if (hit) begin
                        if (r_op == OP_LOAD) begin
                            rdata <= hit_line[{lk_word, 6'b0} +: 64];
                        end else begin
                            data_q[lk_set][hit_way]  <= hit_merged;
                            dirty_q[lk_set][hit_way] <= 1'b1;
                        end
                        for (int unsigned w = 0; w < WAYS; w++)
                            age_q[lk_set][WAY_W'(w)] <= lru_next[w];
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        r_way    <= victim_way;
                        drequest <= 1'b1;
                        if (valid_q[lk_set][victim_way] && dirty_q[lk_set][victim_way]) begin
                            dwrenable <= 1'b1;
                            daddr     <= {tag_q[lk_set][victim_way], lk_set, 6'b0};
                            dwdata    <= data_q[lk_set][victim_way];
                            state     <= S_WB;
                        end else begin
                            dwrenable <= 1'b0;
                            daddr     <= {r_addr[ADDR_W-1:6], 6'b0};
                            state     <= S_FILL;
                        end
                    end
                end
                S_WB: begin
                    if (ddone) begin
                        valid_q[lk_set][r_way] <= 1'b0;
                        dirty_q[lk_set][r_way] <= 1'b0;
                        drequest  <= 1'b1;
                        dwrenable <= 1'b0;
                        daddr     <= {r_addr[ADDR_W-1:6], 6'b0};
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (ddone) begin
                        data_q[lk_set][r_way]  <= fill_line;
                        tag_q[lk_set][r_way]   <= lk_tag;
                        valid_q[lk_set][r_way] <= 1'b1;
                        dirty_q[lk_set][r_way] <= (r_op == OP_STORE);
                        for (int unsigned w = 0; w < WAYS; w++)
                            age_q[lk_set][WAY_W'(w)] <= lru_next[w];
                        if (r_op == OP_LOAD) rdata <= drdata[{lk_word, 6'b0} +: 64];
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_FLUSH_SCAN: begin
                    if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
                        drequest  <= 1'b1;
                        dwrenable <= 1'b1;
                        daddr     <= {tag_q[scan_set][scan_way], scan_set, 6'b0};
                        dwdata    <= data_q[scan_set][scan_way];
                        state     <= S_FLUSH_WB;
                    end else begin
                        valid_q[scan_set][scan_way] <= 1'b0;
                        dirty_q[scan_set][scan_way] <= 1'b0;
                        if (scan_last) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else if (scan_way == WAY_W'(WAYS - 1)) begin
                            scan_way <= '0;
                            scan_set <= scan_set + 1'b1;
                        end else begin
                            scan_way <= scan_way + 1'b1;
                        end
                    end
                end
                S_FLUSH_WB: begin
                    if (ddone) begin
                        valid_q[fl_set][fl_way] <= 1'b0;
                        dirty_q[fl_set][fl_way] <= 1'b0;
                        if (r_op != OP_FLUSH || scan_last) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            if (scan_way == WAY_W'(WAYS - 1)) begin
                                scan_way <= '0;
                                scan_set <= scan_set + 1'b1;
                            end else begin
                                scan_way <= scan_way + 1'b1;
                            end
                            state <= S_FLUSH_SCAN;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Misaligned requests are flagged in simulation; the low bits are dropped.
    always_ff @(posedge clk) begin
        if (reset_n && state == S_IDLE && enable)
            assert (addr[2:0] == 3'b000)
            else $error("dcache_assoc: unaligned address %h", addr);
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: scoreboard bench for dcache_assoc against a flat golden
// memory and a simple latency-modelled memory responder.
module tb_dcache_assoc;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [1:0]   op;
    logic [63:0]  addr;
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
    logic [63:0]  rdata;
    logic         done;
    logic         busy;
    logic         drequest;
    logic         dreqack = 1'b0;
    logic         dwrenable;
    logic [63:0]  daddr;
    logic [511:0] dwdata;
    logic [511:0] drdata = '0;
    logic         ddone = 1'b0;

    dcache_assoc #(.WAYS(4), .SET_BITS(6), .LINE_BYTES(64), .ADDR_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .op(op), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .done(done), .busy(busy),
        .drequest(drequest), .dreqack(dreqack), .dwrenable(dwrenable),
        .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .ddone(ddone)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- golden memory ----------------
    function automatic logic [63:0] init_word(input logic [63:0] a);
        if (a == 64'h1008) return 64'h00000000000000AA;
        return {~a[31:0], a[31:0]};
    endfunction

    logic [63:0] gold [logic [63:0]];

    function automatic logic [63:0] gold_read(input logic [63:0] a);
        if (gold.exists(a)) return gold[a];
        return init_word(a);
    endfunction

    function automatic void gold_write(input logic [63:0] a, input logic [63:0] wd, input logic [7:0] ws);
        logic [63:0] v;
        logic [2:0]  bi;
        v = gold_read(a);
        for (int b = 0; b < 8; b++) begin
            bi = 3'(b);
            if (ws[b]) v[{bi, 3'b000} +: 8] = wd[{bi, 3'b000} +: 8];
        end
        gold[a] = v;
    endfunction

    // ---------------- memory responder ----------------
    logic [511:0] mem [logic [63:0]];
    int unsigned  rd_cnt = 0;
    int unsigned  wr_cnt = 0;
    logic [63:0]  last_rd = '0;
    logic [63:0]  wr_log [$];

    function automatic logic [511:0] mem_line(input logic [63:0] la);
        logic [511:0] l;
        logic [2:0]   i3;
        if (mem.exists(la)) return mem[la];
        for (int i = 0; i < 8; i++) begin
            i3 = 3'(i);
            l[{i3, 6'b0} +: 64] = init_word(la + {58'b0, i3, 3'b000});
        end
        return l;
    endfunction

    logic         m_busy = 1'b0;
    int           m_cnt  = 0;
    logic         m_wr   = 1'b0;
    logic [63:0]  m_addr = '0;
    logic [511:0] m_data = '0;

    always @(posedge clk) begin
        dreqack <= 1'b0;
        ddone   <= 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                ddone <= 1'b1;
                if (m_wr) mem[m_addr] = m_data;
                else drdata <= mem_line(m_addr);
            end else begin
                m_cnt--;
            end
        end else if (drequest) begin
            m_busy = 1'b1;
            m_cnt  = 3;
            m_wr   = dwrenable;
            m_addr = daddr;
            m_data = dwdata;
            dreqack <= 1'b1;
            if (dwrenable) begin
                wr_cnt++;
                wr_log.push_back(daddr);
            end else begin
                rd_cnt++;
                last_rd = daddr;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  op;
        logic [63:0] data;
    } sb_t;

    sb_t         sb [$];
    int unsigned done_cnt = 0;

    always @(negedge clk) begin : monitor
        sb_t e;
        if (reset_n && done) begin
            done_cnt++;
            check("sb_depth_at_done", 64'(sb.size()), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.op == 2'd0) check("load_rdata", rdata, e.data);
            end
        end
    end

    int unsigned op_lat;
    int unsigned op_rd;
    int unsigned op_wr;

    task automatic do_op(input logic [1:0] o, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] ws);
        sb_t         e;
        int unsigned rd0, wr0;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        e.op   = o;
        e.data = (o == 2'd0) ? gold_read(a) : 64'd0;
        sb.push_back(e);
        if (o == 2'd1) gold_write(a, wd, ws);
        enable = 1'b1; op = o; addr = a; wdata = wd; wstrb = ws;
        @(negedge clk);
        enable = 1'b0;
        op_lat = 1;
        while (!done && op_lat < 3000) begin
            @(negedge clk);
            op_lat++;
        end
        check("op_done_seen", {63'b0, done}, 64'd1);
        op_rd = rd_cnt - rd0;
        op_wr = wr_cnt - wr0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        reset_n = 1'b1;
    endtask

    localparam logic [63:0] A0 = 64'h10000, A1 = 64'h11000, A2 = 64'h12000,
                            A3 = 64'h13000, A4 = 64'h14000;

    int unsigned dn0, rd1, wr1, wait_cyc;

    initial begin
        reset_n = 1'b0; enable = 1'b0; op = '0; addr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_drequest", {63'b0, drequest}, 64'd0);
        check("rst_dwrenable", {63'b0, dwrenable}, 64'd0);
        check("rst_daddr", daddr, 64'd0);
        check("rst_dwdata_any", {63'b0, |dwdata}, 64'd0);
        reset_n = 1'b1;

        // 1: cold miss fill, then hit in same line
        do_op(2'd0, 64'h1000, '0, '0);
        check("t1_fill_reads", 64'(op_rd), 64'd1);
        check("t1_fill_addr", last_rd, 64'h1000);
        check("t1_fill_writes", 64'(op_wr), 64'd0);
        do_op(2'd0, 64'h1008, '0, '0);
        check("t1_hit_latency", 64'(op_lat), 64'd2);
        check("t1_hit_traffic", 64'(op_rd + op_wr), 64'd0);
        check("t1_hit_data", rdata, 64'hAA);

        // 2: partial store hit, then reload
        do_op(2'd1, 64'h1008, 64'h1122334455667788, 8'h0F);
        check("t2_store_latency", 64'(op_lat), 64'd2);
        check("t2_store_traffic", 64'(op_rd + op_wr), 64'd0);
        do_op(2'd0, 64'h1008, '0, '0);
        check("t2_merged", rdata, 64'h0000000055667788);

        // store miss: write-allocate with merge from the fill line
        do_op(2'd1, 64'h20048, 64'hDEADBEEFCAFEF00D, 8'hF0);
        check("t2_storemiss_reads", 64'(op_rd), 64'd1);
        do_op(2'd0, 64'h20048, '0, '0);
        check("t2_storemiss_hit", 64'(op_lat), 64'd2);

        // 3: five tags in set 0, LRU eviction of the dirty first line
        apply_reset();
        do_op(2'd1, A0, 64'h0123456789ABCDEF, 8'hFF);
        do_op(2'd0, A1, '0, '0);
        do_op(2'd0, A2, '0, '0);
        do_op(2'd0, A3, '0, '0);
        wr_log.delete();
        do_op(2'd0, A4, '0, '0);
        check("t3_evict_writes", 64'(op_wr), 64'd1);
        check("t3_evict_addr", (wr_log.size() > 0) ? wr_log[0] : 64'hX, A0);
        check("t3_evict_reads", 64'(op_rd), 64'd1);
        check("t3_fill_addr", last_rd, A4);
        do_op(2'd0, A0, '0, '0);
        check("t3_reload_reads", 64'(op_rd), 64'd1);
        check("t3_reload_clean_victim", 64'(op_wr), 64'd0);

        // 4: clflush cases (wstrb=0 store still marks the line dirty)
        do_op(2'd1, A4, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        check("t4_zero_strb_hit", 64'(op_lat), 64'd2);
        wr_log.delete();
        do_op(2'd2, A4, '0, '0);
        check("t4_dirty_flush_writes", 64'(op_wr), 64'd1);
        check("t4_dirty_flush_addr", (wr_log.size() > 0) ? wr_log[0] : 64'hX, A4);
        do_op(2'd0, A4, '0, '0);
        check("t4_after_flush_miss", 64'(op_rd), 64'd1);
        do_op(2'd2, A2, '0, '0);
        check("t4_clean_flush_traffic", 64'(op_rd + op_wr), 64'd0);
        do_op(2'd0, A2, '0, '0);
        check("t4_clean_flush_miss", 64'(op_rd), 64'd1);
        do_op(2'd2, 64'h70000, '0, '0);
        check("t4_miss_flush_traffic", 64'(op_rd + op_wr), 64'd0);
        check("t4_miss_flush_latency", 64'(op_lat), 64'd2);

        // 5: flush_all with dirty lines in sets 0 and 63
        apply_reset();
        do_op(2'd1, 64'h30000, 64'hAAAA_0000_0000_0001, 8'hFF);
        do_op(2'd1, 64'h30FC0, 64'hBBBB_0000_0000_003F, 8'hFF);
        do_op(2'd0, 64'h30140, '0, '0);
        wr_log.delete();
        dn0 = done_cnt;
        do_op(2'd3, 64'd0, '0, '0);
        check("t5_flush_writes", 64'(op_wr), 64'd2);
        check("t5_flush_reads", 64'(op_rd), 64'd0);
        check("t5_wb_first", (wr_log.size() > 0) ? wr_log[0] : 64'hX, 64'h30000);
        check("t5_wb_second", (wr_log.size() > 1) ? wr_log[1] : 64'hX, 64'h30FC0);
        check("t5_done_once", 64'(done_cnt - dn0), 64'd1);
        do_op(2'd0, 64'h30000, '0, '0);
        check("t5_miss_set0", 64'(op_rd), 64'd1);
        do_op(2'd0, 64'h30FC0, '0, '0);
        check("t5_miss_set63", 64'(op_rd), 64'd1);
        do_op(2'd0, 64'h30140, '0, '0);
        check("t5_miss_set5", 64'(op_rd), 64'd1);

        // 6: reset during a writeback
        apply_reset();
        do_op(2'd1, 64'h40000, 64'h5555_6666_7777_8888, 8'hFF);
        do_op(2'd0, 64'h41000, '0, '0);
        do_op(2'd0, 64'h42000, '0, '0);
        do_op(2'd0, 64'h43000, '0, '0);
        @(negedge clk);
        enable = 1'b1; op = 2'd0; addr = 64'h44000; wdata = '0; wstrb = '0;
        @(negedge clk);
        enable = 1'b0;
        wait_cyc = 0;
        while (!(drequest && dwrenable) && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("t6_wb_started", {63'b0, drequest && dwrenable}, 64'd1);
        reset_n = 1'b0;
        dn0 = done_cnt;
        @(negedge clk);
        check("t6_rst_drequest", {63'b0, drequest}, 64'd0);
        check("t6_rst_dwrenable", {63'b0, dwrenable}, 64'd0);
        check("t6_rst_daddr", daddr, 64'd0);
        check("t6_rst_dwdata_any", {63'b0, |dwdata}, 64'd0);
        check("t6_rst_busy", {63'b0, busy}, 64'd0);
        check("t6_rst_rdata", rdata, 64'd0);
        sb.delete();
        reset_n = 1'b1;
        rd1 = rd_cnt;
        wr1 = wr_cnt;
        repeat (12) @(negedge clk);
        check("t6_no_done", 64'(done_cnt - dn0), 64'd0);
        check("t6_idle_busy", {63'b0, busy}, 64'd0);
        check("t6_no_new_request", 64'(rd_cnt - rd1 + wr_cnt - wr1), 64'd0);
        do_op(2'd0, 64'h41000, '0, '0);
        check("t6_cache_empty", 64'(op_rd), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
